pixel_clip_fb_writer: RTL and testbench

PIXEL_CLIP_FB_WRITER -- requirements
Module: pixel_clip_fb_writer

---
 rtl/pixel_clip_fb_writer.sv | 156 +++++++++++++++
 tb/tb_pixel_clip_fb_writer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_clip_fb_writer.sv
// Clips signed pixels to SCR_W x SCR_H and queues in-range ones as framebuffer writes (optional PIXEL_DEDUP_EN drops repeated coords).
// Latency: push -> fb_we one cycle; pix_ready low when queue full or not running; fb_* held until fb_ack.
module pixel_clip_fb_writer #(
   parameter int SCR_W      = 256,
   parameter int SCR_H      = 128,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_valid,
   output logic        pix_ready,
   input  logic [8:0]  x_in,
   input  logic [7:0]  y_in,
   input  logic [7:0]  color_in,
   input  logic        draw_done,
   input  logic        clear,
   output logic        fb_we,
   output logic [14:0] fb_addr,
   output logic [7:0]  fb_data,
   input  logic        fb_ack,
   output logic        frame_done,
   output logic [15:0] pix_written,
   output logic [15:0] pix_clipped
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } fb_ent_t;

   state_t        state_q, state_d;
   logic          frame_done_q, frame_done_d;
   logic          run_en_q;
   fb_ent_t       mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d, rem;
   logic          fb_we_q, fb_we_d;
   fb_ent_t       out_q, out_d;
   logic [15:0]   written_q, written_d, clipped_q, clipped_d;
   logic          accept, clip, dup, push, pop;
   fb_ent_t       push_ent;

   assign pix_ready = run_en_q && (state_q == S_RUN) && (cnt_q != FULL_CNT);
   assign accept    = pix_valid && pix_ready;
   assign clip      = x_in[8] || y_in[7] ||
                      (int'($signed(x_in)) >= SCR_W) || (int'($signed(y_in)) >= SCR_H);
   assign push      = accept && !clip && !dup;
   assign pop       = fb_we_q && fb_ack;

   assign push_ent.addr = 15'(int'(y_in[6:0]) * SCR_W + int'(x_in[7:0]));
   assign push_ent.data = color_in;

`ifdef PIXEL_DEDUP_EN
   logic       last_vld_q;
   logic [8:0] last_x_q;
   logic [7:0] last_y_q;

   assign dup = last_vld_q && (x_in == last_x_q) && (y_in == last_y_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_vld_q <= 1'b0;
         last_x_q   <= '0;
         last_y_q   <= '0;
      end else if (state_q != S_DONE && state_d == S_DONE) begin
         last_vld_q <= 1'b0;
      end else if (push) begin
         last_vld_q <= 1'b1;
         last_x_q   <= x_in;
         last_y_q   <= y_in;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Output stage excludes this cycle's push, which gives the one-cycle
   // push-to-fb_we latency while still retiring one entry per cycle under ack.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      rem      = cnt_q - (AW+1)'(pop);
      fb_we_d  = (rem != '0);
      out_d    = fb_we_d ? mem_q[rd_ptr_d] : out_q;
   end

   always_comb begin
      written_d = written_q;
      clipped_d = clipped_q;
      if (clear) begin
         written_d = '0;
         clipped_d = '0;
      end else begin
         if (pop && written_q != 16'hFFFF)
            written_d = written_q + 16'd1;
         if (accept && clip && clipped_q != 16'hFFFF)
            clipped_d = clipped_q + 16'd1;
      end
   end

   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      case (state_q)
         S_RUN:   if (draw_done) state_d = S_DRAIN;
         S_DRAIN: if (cnt_q == '0 && !fb_we_q) begin
                     state_d      = S_DONE;
                     frame_done_d = 1'b1;
                  end
         S_DONE:  if (!draw_done) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= push_ent;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_RUN;
         frame_done_q <= 1'b0;
         run_en_q     <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         fb_we_q      <= 1'b0;
         out_q        <= '0;
         written_q    <= '0;
         clipped_q    <= '0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= frame_done_d;
         run_en_q     <= 1'b1;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         fb_we_q      <= fb_we_d;
         out_q        <= out_d;
         written_q    <= written_d;
         clipped_q    <= clipped_d;
      end
   end

   assign fb_we       = fb_we_q;
   assign fb_addr     = out_q.addr;
   assign fb_data     = out_q.data;
   assign frame_done  = frame_done_q;
   assign pix_written = written_q;
   assign pix_clipped = clipped_q;
endmodule

// File: tb/tb_pixel_clip_fb_writer.sv
// Directed bench for pixel_clip_fb_writer: clipping, queue backpressure, drain/frame_done, clear, dedup, async reset.
module tb_pixel_clip_fb_writer;
   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid, pix_ready;
   logic [8:0]  x_in;
   logic [7:0]  y_in, color_in;
   logic        draw_done, clear;
   logic        fb_we;
   logic [14:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_ack, frame_done;
   logic [15:0] pix_written, pix_clipped;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   logic [14:0] wr_q [$];

   pixel_clip_fb_writer dut (
      .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .x_in(x_in), .y_in(y_in), .color_in(color_in), .draw_done(draw_done),
      .clear(clear), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_ack(fb_ack), .frame_done(frame_done), .pix_written(pix_written),
      .pix_clipped(pix_clipped)
   );

   always #5 clk = ~clk;

   // Handshakes seen at the negedge complete on the following rising edge.
   always @(negedge clk) begin
      if (reset && fb_we && fb_ack) begin
         wr_q.push_back(fb_addr);
         wr_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [8:0] x, input logic [7:0] y, input logic [7:0] c);
      int n = 0;
      pix_valid = 1'b1;
      x_in      = x;
      y_in      = y;
      color_in  = c;
      while (!pix_ready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", 32'(pix_ready), 32'd1);
      tick();
      pix_valid = 1'b0;
   endtask

   initial begin
      int n;
      int ack_tick, fd_tick, fd_count, wr_before;
      reset = 1'b0; pix_valid = 1'b0; x_in = '0; y_in = '0; color_in = '0;
      draw_done = 1'b0; clear = 1'b0; fb_ack = 1'b0;

      #2;
      chk("rst_ready", 32'(pix_ready), 32'd0);
      chk("rst_we", 32'(fb_we), 32'd0);
      chk("rst_addr", 32'(fb_addr), 32'd0);
      chk("rst_data", 32'(fb_data), 32'd0);
      chk("rst_fdone", 32'(frame_done), 32'd0);
      chk("rst_written", 32'(pix_written), 32'd0);
      chk("rst_clipped", 32'(pix_clipped), 32'd0);
      tick(); tick();
      reset = 1'b1;
      chk("rel_ready_low", 32'(pix_ready), 32'd0);
      tick();
      chk("rel_ready_high", 32'(pix_ready), 32'd1);

      // Single write, ack held high
      fb_ack = 1'b1;
      send(9'd10, 8'd5, 8'h3C);
      chk("s1_latency_we", 32'(fb_we), 32'd0);
      tick();
      chk("s1_we", 32'(fb_we), 32'd1);
      chk("s1_addr", 32'(fb_addr), 32'd1290);
      chk("s1_data", 32'(fb_data), 32'h3C);
      tick();
      chk("s1_we_fall", 32'(fb_we), 32'd0);
      chk("s1_written", 32'(pix_written), 32'd1);

      // Clipped pixels on every edge
      send(9'h1FF, 8'd0, 8'h01);
      send(9'd256, 8'd3, 8'h02);
      send(9'd4, 8'hFE, 8'h03);
      send(9'd0, 8'd128, 8'h04);
      tick(); tick();
      chk("s2_clipped", 32'(pix_clipped), 32'd4);
      chk("s2_no_write", 32'(wr_cnt), 32'd1);
      chk("s2_we", 32'(fb_we), 32'd0);

      // Far corner of the visible area
      send(9'd255, 8'd127, 8'hA5);
      tick();
      chk("corner_addr", 32'(fb_addr), 32'd32767);
      chk("corner_data", 32'(fb_data), 32'hA5);
      tick();
      chk("corner_written", 32'(pix_written), 32'd2);

      // Backpressure: queue fills at four with ack held low
      fb_ack = 1'b0;
      for (int i = 0; i < 4; i++)
         send(9'(i + 1), 8'd1, 8'(i));
      pix_valid = 1'b1; x_in = 9'd5; y_in = 8'd1; color_in = 8'd4;
      chk("s3_full_ready", 32'(pix_ready), 32'd0);
      chk("s3_we_held", 32'(fb_we), 32'd1);
      chk("s3_addr_head", 32'(fb_addr), 32'd257);
      tick(); tick(); tick();
      chk("s3_addr_stable", 32'(fb_addr), 32'd257);
      chk("s3_ready_stuck", 32'(pix_ready), 32'd0);
      fb_ack = 1'b1;
      send(9'd5, 8'd1, 8'd4);
      n = 0;
      while (wr_cnt != 7 && n < 40) begin
         tick();
         n++;
      end
      chk("s3_drain_count", 32'(wr_cnt), 32'd7);
      tick();
      chk("s3_written", 32'(pix_written), 32'd7);
      for (int i = 0; i < 5; i++)
         chk("s3_order", 32'(wr_q[i + 2]), 32'(257 + i));

      // Drain and frame_done timing
      send(9'd20, 8'd2, 8'h11);
      send(9'd21, 8'd2, 8'h12);
      send(9'd22, 8'd2, 8'h13);
      draw_done = 1'b1;
      ack_tick = -1; fd_tick = -1; fd_count = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (wr_cnt == 10 && ack_tick < 0) ack_tick = k;
         if (frame_done) begin
            fd_count++;
            fd_tick = k;
         end
      end
      chk("s4_fd_once", 32'(fd_count), 32'd1);
      chk("s4_fd_timing", 32'(fd_tick), 32'(ack_tick + 1));
      chk("s4_written", 32'(pix_written), 32'd10);
      chk("s4_done_ready", 32'(pix_ready), 32'd0);
      draw_done = 1'b0;
      tick();
      chk("s4_back_run", 32'(pix_ready), 32'd1);

      // Clear wins over a same-cycle write completion
      send(9'd30, 8'd3, 8'h55);
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_written", 32'(pix_written), 32'd0);
      chk("clr_clipped", 32'(pix_clipped), 32'd0);
      chk("clr_write_done", 32'(wr_cnt), 32'd11);

      // Repeated coordinates
      send(9'd7, 8'd7, 8'h21);
      send(9'd7, 8'd7, 8'h22);
      tick(); tick(); tick(); tick();
`ifdef PIXEL_DEDUP_EN
      chk("dedup_written", 32'(pix_written), 32'd1);
`else
      chk("dedup_written", 32'(pix_written), 32'd2);
`endif
      send(9'h1FF, 8'd9, 8'h00);
      tick();
      chk("clip_after_clr", 32'(pix_clipped), 32'd1);

      // Asynchronous reset with a write in flight
      fb_ack = 1'b0;
      send(9'd9, 8'd9, 8'h77);
      tick();
      chk("rst_mid_we", 32'(fb_we), 32'd1);
      wr_before = wr_cnt;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_we", 32'(fb_we), 32'd0);
      chk("arst_addr", 32'(fb_addr), 32'd0);
      chk("arst_written", 32'(pix_written), 32'd0);
      chk("arst_clipped", 32'(pix_clipped), 32'd0);
      chk("arst_ready", 32'(pix_ready), 32'd0);
      tick();
      reset = 1'b1;
      fb_ack = 1'b1;
      chk("arst_rel_ready", 32'(pix_ready), 32'd0);
      tick();
      chk("arst_ready_up", 32'(pix_ready), 32'd1);
      chk("arst_no_we", 32'(fb_we), 32'd0);
      tick(); tick();
      chk("arst_no_count", 32'(pix_written), 32'd0);
      chk("arst_no_write", 32'(wr_cnt), 32'(wr_before));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
